// File: rtl/i2c_slave_regfile.sv
// I2C target with a byte-wide register file, an auto-incrementing register
// pointer, multi-byte reads/writes and repeated START support. SCL and SDA are
// oversampled on clk; SDA is driven open-drain (low or released only).
`timescale 1ns/1ps
module i2c_slave_regfile #(
    parameter logic [6:0] SLAVE_ADDR = 7'h2A,
    parameter int         NUM_REGS   = 8,
    parameter logic [7:0] RESET_VAL  = 8'h00,
    parameter int         PTR_W      = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             scl,
    inout  wire              sda,
    output logic             sda_oe,
    output logic             busy,
    output logic             wr_strobe,
    output logic [PTR_W-1:0] wr_index,
    output logic [7:0]       wr_data
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK,
        WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
    } state_t;

    state_t state_q, state_d;

    logic scl_meta, scl_sync, scl_d;
    logic sda_meta, sda_sync, sda_d;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift_q;
    logic [7:0]       tx_q;
    logic             rw_q;
    logic [PTR_W-1:0] ptr_q;
    logic [7:0]       regs [NUM_REGS];

    logic             oe_d;
    logic [7:0]       byte_in;
    logic [PTR_W-1:0] ptr_inc;

    // Open-drain pad: only ever pull low, otherwise let the bus pull-up win.
    assign sda = sda_oe ? 1'b0 : 1'bz;

    wire scl_rise   = scl_sync & ~scl_d;
    wire scl_fall   = ~scl_sync & scl_d;
    wire start_det  = scl_sync & sda_d & ~sda_sync;
    wire stop_det   = scl_sync & ~sda_d & sda_sync;
    wire last_bit   = (bit_cnt == 3'd7);
    wire addr_match = (byte_in[7:1] == SLAVE_ADDR) && (byte_in[7:1] != 7'd0);
    wire ptr_ok     = ({1'b0, byte_in} < 9'(NUM_REGS));

    assign byte_in = {shift_q[6:0], sda_sync};
    assign ptr_inc = (ptr_q == PTR_W'(NUM_REGS - 1)) ? '0 : ptr_q + PTR_W'(1);

    // Two-flop synchronisers followed by an edge register on each bus line.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scl_meta <= 1'b1; scl_sync <= 1'b1; scl_d <= 1'b1;
            sda_meta <= 1'b1; sda_sync <= 1'b1; sda_d <= 1'b1;
        end else begin
            // NOTE: non-blocking so every stage captures its predecessor's old value.
            scl_meta <= scl;      scl_sync <= scl_meta; scl_d <= scl_sync;
            sda_meta <= sda;      sda_sync <= sda_meta; sda_d <= sda_sync;
        end
    end

    // Protocol state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next state and next SDA drive level; START/STOP override bit sampling.
    always_comb begin
        // NOTE: defaults first so no path leaves a value unassigned (no latches).
        state_d = state_q;
        oe_d    = 1'b0;
        if (start_det) begin
            state_d = ADDR;
        end else if (stop_det) begin
            state_d = IDLE;
        end else if (scl_rise) begin
            case (state_q)
                ADDR:      if (last_bit) state_d = addr_match ? ADDR_ACK : IGNORE;
                ADDR_ACK:  state_d = rw_q ? RDATA : PTR;
                PTR:       if (last_bit) state_d = ptr_ok ? PTR_ACK : IGNORE;
                PTR_ACK:   state_d = WDATA;
                WDATA:     if (last_bit) state_d = WDATA_ACK;
                WDATA_ACK: state_d = WDATA;
                RDATA:     if (last_bit) state_d = RDATA_ACK;
                RDATA_ACK: state_d = sda_sync ? IGNORE : RDATA;
                default:   state_d = state_q;
            endcase
        end
        case (state_q)
            ADDR_ACK, PTR_ACK, WDATA_ACK: oe_d = 1'b1;
            RDATA:                        oe_d = ~tx_q[7];
            default:                      oe_d = 1'b0;
        endcase
    end

    // Shift registers, pointer, register file, SDA drive and status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt   <= '0;
            shift_q   <= '0;
            tx_q      <= '0;
            rw_q      <= 1'b0;
            ptr_q     <= '0;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            wr_strobe <= 1'b0;
            wr_index  <= '0;
            wr_data   <= '0;
            // NOTE: the register file must come up at RESET_VAL, so it is reset
            // explicitly here rather than left as an unreset memory.
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
        end else begin
            wr_strobe <= 1'b0;

            if (stop_det || state_d == IGNORE)
                busy <= 1'b0;
            else if (state_q == ADDR && state_d == ADDR_ACK)
                busy <= 1'b1;

            if (start_det || stop_det) begin
                bit_cnt <= '0;
                sda_oe  <= 1'b0;
            end else begin
                if (scl_fall) sda_oe <= oe_d;
                if (scl_rise) begin
                    case (state_q)
                        ADDR, PTR, WDATA: begin
                            shift_q <= byte_in;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (last_bit) begin
                                if (state_q == ADDR) rw_q <= byte_in[0];
                                if (state_q == PTR && ptr_ok) ptr_q <= byte_in[PTR_W-1:0];
                                if (state_q == WDATA) begin
                                    regs[ptr_q] <= byte_in;
                                    wr_strobe   <= 1'b1;
                                    wr_index    <= ptr_q;
                                    wr_data     <= byte_in;
                                    ptr_q       <= ptr_inc;
                                end
                            end
                        end
                        ADDR_ACK: begin
                            bit_cnt <= '0;
                            if (rw_q) tx_q <= regs[ptr_q];
                        end
                        PTR_ACK, WDATA_ACK: bit_cnt <= '0;
                        RDATA: begin
                            tx_q    <= {tx_q[6:0], 1'b0};
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                        RDATA_ACK: begin
                            bit_cnt <= '0;
                            ptr_q   <= ptr_inc;
                            tx_q    <= regs[ptr_inc];
                        end
                        default: bit_cnt <= '0;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Directed bench for i2c_slave_regfile: a bit-banged I2C master drives the
// open-drain bus and every expected value is written out by hand.
`timescale 1ns/1ps
module tb_i2c_slave_regfile;

    localparam int         Q      = 100;      // quarter SCL period (10 clk)
    localparam logic [7:0] ADDR_W = 8'h54;    // 0x2A, write
    localparam logic [7:0] ADDR_R = 8'h55;    // 0x2A, read

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       scl = 1'b1;
    logic       m_sda_low = 1'b0;
    wire        sda;
    logic       sda_oe, busy, wr_strobe;
    logic [2:0] wr_index;
    logic [7:0] wr_data;

    int checks = 0;
    int errors = 0;

    // Bus monitor (sampled on the falling clk edge).
    int         strobe_cnt = 0;
    int         oe_cnt     = 0;
    int         busy_cnt   = 0;
    logic [7:0] log_idx[$];
    logic [7:0] log_dat[$];

    assign sda = m_sda_low ? 1'b0 : 1'bz;
    pullup (sda);

    always #5 clk = ~clk;

    i2c_slave_regfile dut (
        .clk       (clk),
        .rst       (rst),
        .scl       (scl),
        .sda       (sda),
        .sda_oe    (sda_oe),
        .busy      (busy),
        .wr_strobe (wr_strobe),
        .wr_index  (wr_index),
        .wr_data   (wr_data)
    );

    always @(negedge clk) begin
        if (wr_strobe) begin
            log_idx.push_back(8'(wr_index));
            log_dat.push_back(wr_data);
            strobe_cnt++;
        end
        if (sda_oe) oe_cnt++;
        if (busy)   busy_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic bus_start();
        m_sda_low = 1'b0; #Q;
        scl = 1'b1;       #Q;
        m_sda_low = 1'b1; #Q;
        scl = 1'b0;       #Q;
    endtask

    task automatic bus_stop();
        m_sda_low = 1'b1; #Q;
        scl = 1'b1;       #Q;
        m_sda_low = 1'b0; #Q;
    endtask

    task automatic put_bit(input logic b);
        m_sda_low = ~b; #Q;
        scl = 1'b1;     #(2*Q);
        scl = 1'b0;     #Q;
    endtask

    task automatic get_bit(output logic b);
        m_sda_low = 1'b0; #Q;
        scl = 1'b1;       #Q;
        b = sda;          #Q;
        scl = 1'b0;       #Q;
    endtask

    task automatic put_byte(input logic [7:0] d, output logic acked);
        logic b;
        for (int i = 7; i >= 0; i--) put_bit(d[i]);
        get_bit(b);
        acked = ~b;
    endtask

    task automatic get_byte(output logic [7:0] d, input logic ack);
        logic b;
        d = '0;
        for (int i = 0; i < 8; i++) begin
            get_bit(b);
            d = {d[6:0], b};
        end
        put_bit(~ack);
    endtask

    // Point the slave at register p, then repeated-START into a read.
    task automatic point_and_read(input logic [7:0] p, input string tag);
        logic a;
        bus_start();
        put_byte(ADDR_W, a); check({tag, "_addr_w_ack"}, a, 1'b1);
        put_byte(p, a);      check({tag, "_ptr_ack"}, a, 1'b1);
        bus_start();
        put_byte(ADDR_R, a); check({tag, "_addr_r_ack"}, a, 1'b1);
    endtask

    initial begin
        #(3_000_000);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic       a;
        logic       b;
        logic [7:0] d;
        int         s0, o0, b0;

        // Reset state
        #22;
        check("rst_sda_oe",    sda_oe,    1'b0);
        check("rst_busy",      busy,      1'b0);
        check("rst_wr_strobe", wr_strobe, 1'b0);
        check("rst_wr_index",  wr_index,  3'd0);
        check("rst_wr_data",   wr_data,   8'h00);
        rst = 1'b1;
        #(Q+8);

        // Write ptr 3: 0xAA, 0x55
        s0 = strobe_cnt;
        bus_start();
        put_byte(ADDR_W, a); check("wr_addr_ack", a, 1'b1);
        check("wr_busy_hi", busy, 1'b1);
        put_byte(8'h03, a);  check("wr_ptr_ack", a, 1'b1);
        put_byte(8'hAA, a);  check("wr_d0_ack", a, 1'b1);
        put_byte(8'h55, a);  check("wr_d1_ack", a, 1'b1);
        bus_stop();
        check("wr_busy_lo", busy, 1'b0);
        check("wr_strobes", strobe_cnt - s0, 2);
        check("wr_idx0", log_idx[s0],   8'd3);
        check("wr_dat0", log_dat[s0],   8'hAA);
        check("wr_idx1", log_idx[s0+1], 8'd4);
        check("wr_dat1", log_dat[s0+1], 8'h55);

        // Read back via repeated START
        point_and_read(8'h03, "rd");
        get_byte(d, 1'b1); check("rd_reg3", d, 8'hAA);
        get_byte(d, 1'b0); check("rd_reg4", d, 8'h55);
        check("rd_oe_after_nack",   sda_oe, 1'b0);
        check("rd_busy_after_nack", busy,   1'b0);
        bus_stop();

        // Address mismatch (0x2B)
        s0 = strobe_cnt; o0 = oe_cnt; b0 = busy_cnt;
        bus_start();
        put_byte(8'h56, a); check("mm_addr_nack", a, 1'b0);
        put_byte(8'h01, a); check("mm_ptr_nack",  a, 1'b0);
        put_byte(8'hFF, a); check("mm_data_nack", a, 1'b0);
        bus_stop();
        check("mm_no_oe",     oe_cnt - o0,     0);
        check("mm_no_busy",   busy_cnt - b0,   0);
        check("mm_no_strobe", strobe_cnt - s0, 0);

        // Pointer wrap 7 -> 0
        s0 = strobe_cnt;
        bus_start();
        put_byte(ADDR_W, a); check("wrap_addr_ack", a, 1'b1);
        put_byte(8'h07, a);  check("wrap_ptr_ack", a, 1'b1);
        put_byte(8'h11, a);  check("wrap_d0_ack", a, 1'b1);
        put_byte(8'h22, a);  check("wrap_d1_ack", a, 1'b1);
        bus_stop();
        check("wrap_strobes", strobe_cnt - s0, 2);
        check("wrap_idx0", log_idx[s0],   8'd7);
        check("wrap_idx1", log_idx[s0+1], 8'd0);
        point_and_read(8'h07, "wrap_rd");
        get_byte(d, 1'b1); check("wrap_reg7", d, 8'h11);
        get_byte(d, 1'b0); check("wrap_reg0", d, 8'h22);
        bus_stop();

        // Out-of-range pointer 0x08
        s0 = strobe_cnt;
        bus_start();
        put_byte(ADDR_W, a); check("bad_ptr_addr_ack", a, 1'b1);
        put_byte(8'h08, a);  check("bad_ptr_nack", a, 1'b0);
        check("bad_ptr_busy", busy, 1'b0);
        put_byte(8'h99, a);  check("bad_ptr_data_nack", a, 1'b0);
        bus_stop();
        check("bad_ptr_no_strobe", strobe_cnt - s0, 0);

        // Register 1 untouched by the mismatched transfer
        point_and_read(8'h01, "mm_rd");
        get_byte(d, 1'b0); check("mm_reg1", d, 8'h00);
        bus_stop();

        // Abort after 4 data bits, then read from the current pointer
        s0 = strobe_cnt;
        bus_start();
        put_byte(ADDR_W, a); check("abort_addr_ack", a, 1'b1);
        put_byte(8'h04, a);  check("abort_ptr_ack", a, 1'b1);
        for (int i = 0; i < 4; i++) put_bit(1'b0);
        bus_stop();
        check("abort_no_strobe", strobe_cnt - s0, 0);
        check("abort_busy", busy, 1'b0);
        bus_start();
        put_byte(ADDR_R, a); check("abort_rd_ack", a, 1'b1);
        get_byte(d, 1'b1); check("abort_reg4", d, 8'h55);
        get_byte(d, 1'b0); check("abort_reg5", d, 8'h00);
        bus_stop();

        // Asynchronous reset while the slave is pulling SDA low
        point_and_read(8'h03, "arst");
        get_bit(b); check("arst_bit7", b, 1'b1);
        check("arst_driving0", sda_oe, 1'b1);
        #3 rst = 1'b0;
        #1;
        check("arst_oe_drop", sda_oe, 1'b0);
        check("arst_sda_rel", sda,    1'b1);
        check("arst_busy",    busy,   1'b0);
        #20 rst = 1'b1;
        #(Q+6);
        bus_stop();
        point_and_read(8'h00, "post_rst");
        for (int i = 0; i < 8; i++) begin
            get_byte(d, i < 7);
            check($sformatf("post_rst_reg%0d", i), d, 8'h00);
        end
        bus_stop();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
